// File: rtl/bin_scaler_pkg.sv
// Shared constants, state encoding and log encoder for the waterfall bin path.
package bin_scaler_pkg;

  localparam int BS_FREQ_BINS = 320;
  localparam int BS_ADDR_W    = 9;
  localparam int BS_DATA_W    = 8;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } bs_state_e;

  // L = msb_index*16 + next four bits; magnitudes 0 and 1 map to 0, saturates at 0xFF.
  function automatic logic [7:0] log_enc(input logic [31:0] mag);
    logic [4:0]  p;
    logic [31:0] norm;
    logic [3:0]  m;
    p = '0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) p = 5'(i);
    end
    norm = mag << (5'd31 - p);
    m    = norm[30:27];
    if (mag <= 32'd1) return 8'd0;
    if (p > 5'd15) return 8'hFF;
    return {p[3:0], m};
  endfunction

endpackage

// File: rtl/bin_hist_ram.sv
// Per-bin peak history: synchronous read, single write port, read returns pre-write data.
module bin_hist_ram #(
  parameter int DEPTH  = 320,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/bin_scaler.sv
// Log-compresses spectrum bins and applies per-bin peak-hold with decay before the freq_bram write.
//
// state    | meaning
// ST_CLEAR | zeroing history, one entry per cycle, in_ready low
// ST_RUN   | accepting bins, 2-stage pipeline to out_we
module bin_scaler
  import bin_scaler_pkg::*;
#(
  parameter int IN_W        = 16,
  parameter int OUT_W       = BS_DATA_W,
  parameter int FREQ_BINS   = BS_FREQ_BINS,
  parameter int ADDR_W      = BS_ADDR_W,
  parameter int DECAY_SHIFT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   in_data,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              in_ready,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic [OUT_W-1:0]  out_data,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FREQ_BINS - 1);

  bs_state_e         state;
  logic [ADDR_W-1:0] clr_addr;
  logic              s1_valid;
  logic [ADDR_W-1:0] s1_addr;
  logic [OUT_W-1:0]  s1_lval;

  logic              accept;
  logic [OUT_W-1:0]  ram_rdata;
  logic [OUT_W-1:0]  prev;
  logic [OUT_W-1:0]  keep;
  logic [OUT_W-1:0]  decayed;
  logic [OUT_W-1:0]  result;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [OUT_W-1:0]  ram_wdata;

  assign accept = in_valid && in_ready && (in_addr <= LAST_ADDR);

  // The bin just written is still in flight for the RAM, so take it from the output register.
  always_comb begin
    prev    = (out_we && (out_addr == s1_addr)) ? out_data : ram_rdata;
    keep    = prev - (prev >> DECAY_SHIFT);
    decayed = (keep == '0) ? '0 : keep - 1'b1;
    result  = (s1_lval > decayed) ? s1_lval : decayed;
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = s1_addr;
    ram_wdata = result;
    if (!reset) begin
      if (state == ST_CLEAR) begin
        ram_we    = 1'b1;
        ram_waddr = clr_addr;
        ram_wdata = '0;
      end else begin
        ram_we = s1_valid;
      end
    end
  end

  bin_hist_ram #(
    .DEPTH  (FREQ_BINS),
    .ADDR_W (ADDR_W),
    .DATA_W (OUT_W)
  ) u_hist (
    .clk     (clk),
    .we      (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata),
    .rd_en   (accept),
    .rd_addr (in_addr),
    .rd_data (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_CLEAR;
      clr_addr   <= '0;
      in_ready   <= 1'b0;
      s1_valid   <= 1'b0;
      s1_addr    <= '0;
      s1_lval    <= '0;
      out_we     <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_addr <= in_addr;
        s1_lval <= OUT_W'(log_enc(32'(in_data)));
      end
      out_we     <= s1_valid;
      frame_done <= s1_valid && (s1_addr == LAST_ADDR);
      if (s1_valid) begin
        out_addr <= s1_addr;
        out_data <= result;
      end
      case (state)
        ST_CLEAR: begin
          if (clr_addr == LAST_ADDR) begin
            state    <= ST_RUN;
            in_ready <= 1'b1;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        ST_RUN:  in_ready <= 1'b1;
        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_scaler.sv
// Scoreboard bench for bin_scaler: directed bins, expected outputs queued, monitor checks on negedge.
module tb_bin_scaler;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [15:0] in_data;
  logic [8:0] in_addr;
  logic       in_ready;
  logic       out_we;
  logic [8:0] out_addr;
  logic [7:0] out_data;
  logic       frame_done;

  typedef struct {
    logic [8:0] addr;
    logic [7:0] data;
    logic       fd;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  bin_scaler dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_addr    (in_addr),
    .in_ready   (in_ready),
    .out_we     (out_we),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .frame_done (frame_done)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (out_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_we", int'(out_addr), -1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_addr", int'(out_addr), int'(e.addr));
        check("out_data", int'(out_data), int'(e.data));
        check("frame_done", int'(frame_done), int'(e.fd));
        check("latency_cycle", cyc, e.cyc);
      end
    end else if (frame_done === 1'b1) begin
      check("frame_done_without_we", 1, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int addr, input int mag, input bit push, input int exp_data);
    exp_t e;
    in_valid = 1'b1;
    in_addr  = 9'(addr);
    in_data  = 16'(mag);
    if (push) begin
      e.addr = 9'(addr);
      e.data = 8'(exp_data);
      e.fd   = (addr == 319);
      e.cyc  = cyc + 2;
      exp_q.push_back(e);
    end
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (in_ready !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
  endtask

  int n;

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_addr  = '0;
    repeat (3) tick();
    check("rst_out_we", int'(out_we), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_out_addr", int'(out_addr), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_in_ready", int'(in_ready), 0);

    reset = 1'b0;
    wait_ready(n);
    check("clear_cycles", n, 320);

    // log encoding, back-to-back
    send(0, 16'h0000, 1'b1, 8'h00);
    send(1, 16'h0003, 1'b1, 8'h18);
    send(2, 16'h0180, 1'b1, 8'h88);
    send(3, 16'hFFFF, 1'b1, 8'hFF);
    idle(4);

    // decay across frames, and decay from zero
    send(5, 16'h8000, 1'b1, 8'hF0);
    idle(6);
    send(5, 16'h0000, 1'b1, 8'hD1);
    idle(3);
    send(6, 16'h0000, 1'b1, 8'h00);
    send(6, 16'h0001, 1'b1, 8'h00);
    idle(3);

    // forwarding of in-flight results
    send(7, 16'h8000, 1'b1, 8'hF0);
    send(7, 16'h0000, 1'b1, 8'hD1);
    idle(1);
    send(7, 16'h0003, 1'b1, 8'hB6);
    send(8, 16'h8000, 1'b1, 8'hF0);
    send(8, 16'h0000, 1'b1, 8'hD1);
    send(8, 16'h0000, 1'b1, 8'hB6);
    send(5, 16'hFFFF, 1'b1, 8'hFF);
    idle(4);

    // out-of-range bins dropped, last bin pulses frame_done
    send(320, 16'hFFFF, 1'b0, 0);
    send(511, 16'hFFFF, 1'b0, 0);
    idle(3);
    send(319, 16'h0180, 1'b1, 8'h88);
    idle(4);

    // reset right after accepting a bin
    send(9, 16'h8000, 1'b0, 0);
    reset    = 1'b1;
    in_valid = 1'b0;
    tick();
    check("reset_in_ready", int'(in_ready), 0);
    check("reset_out_we", int'(out_we), 0);
    reset = 1'b0;
    wait_ready(n);
    check("reclear_cycles", n, 320);

    // history must be zero again after the re-run clear
    send(5, 16'h0000, 1'b1, 8'h00);
    send(9, 16'h0000, 1'b1, 8'h00);
    idle(6);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
